// File: rtl/key_pkg.sv
// Shared types and keycodes for the keyboard event arbiter.
// Key constants follow the USB HID usage table (keyboard page).
package key_pkg;

    typedef struct packed {
        logic [7:0] code;
        logic       press;
    } key_event_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } arb_state_t;

    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_ESC   = 8'h29;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;

    // True when code occupies either slot of a two-slot keycode word.
    function automatic logic code_in(input logic [7:0] code, input logic [15:0] slots);
        return (code == slots[7:0]) || (code == slots[15:8]);
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Show-ahead synchronous FIFO of key events; occupancy tracked by a count register.
// Pushes while full are ignored here; the owner decides how to report them.
module event_fifo
    import key_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       push,
    input  key_event_t push_data,
    input  logic       pop,
    output key_event_t head,
    output logic       empty,
    output logic       full
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    key_event_t      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/key_event_arb.sv
// Turns the two-slot keycode level into an ordered press/release event stream
// buffered in a small FIFO with valid/ready pop and a sticky overflow flag.
module key_event_arb
    import key_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] keycode,
    input  logic        ev_ready,
    input  logic        clr_ovf,
    output logic        ev_valid,
    output logic [7:0]  ev_code,
    output logic        ev_press,
    output logic        overflow,
    output logic        any_key
);

    arb_state_t  state_q;
    logic [15:0] snap_q;
    logic [3:0]  pend_q;
    logic [7:0]  pend_code_q [4];

    logic [7:0]  old0, old1, new0, new1;
    logic [3:0]  build_vld;
    logic [1:0]  sel_idx;
    logic [3:0]  pend_left;
    logic        push;
    key_event_t  push_ev;
    key_event_t  head;
    logic        fifo_empty;
    logic        fifo_full;
    logic        drop;

    assign old0 = snap_q[7:0];
    assign old1 = snap_q[15:8];
    assign new0 = keycode[7:0];
    assign new1 = keycode[15:8];

    // Slot1 entries also skip a code already carried by slot0 of the same snapshot.
    always_comb begin
        build_vld    = '0;
        build_vld[0] = (old0 != KEY_NONE) && !code_in(old0, keycode);
        build_vld[1] = (old1 != KEY_NONE) && !code_in(old1, keycode) && (old1 != old0);
        build_vld[2] = (new0 != KEY_NONE) && !code_in(new0, snap_q);
        build_vld[3] = (new1 != KEY_NONE) && !code_in(new1, snap_q) && (new1 != new0);
    end

    always_comb begin
        sel_idx = 2'd3;
        if (pend_q[0]) begin
            sel_idx = 2'd0;
        end else if (pend_q[1]) begin
            sel_idx = 2'd1;
        end else if (pend_q[2]) begin
            sel_idx = 2'd2;
        end
        pend_left = pend_q & ~(4'b0001 << sel_idx);
    end

    // Entries 0/1 are releases, 2/3 are presses, so bit 1 of the index is the press flag.
    always_comb begin
        push          = (state_q == EMIT);
        push_ev       = '0;
        push_ev.code  = pend_code_q[sel_idx];
        push_ev.press = sel_idx[1];
    end

    assign drop = push && fifo_full;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            snap_q   <= '0;
            any_key  <= 1'b0;
            overflow <= 1'b0;
            pend_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                pend_code_q[i] <= KEY_NONE;
            end
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (keycode != snap_q) begin
                        snap_q         <= keycode;
                        any_key        <= |keycode;
                        pend_q         <= build_vld;
                        pend_code_q[0] <= old0;
                        pend_code_q[1] <= old1;
                        pend_code_q[2] <= new0;
                        pend_code_q[3] <= new1;
                        if (|build_vld) begin
                            state_q <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    pend_q <= pend_left;
                    if (pend_left == '0) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    event_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .Clk       (Clk),
        .Reset     (Reset),
        .push      (push),
        .push_data (push_ev),
        .pop       (ev_valid && ev_ready),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign ev_valid = !fifo_empty;
    assign ev_code  = head.code;
    assign ev_press = head.press;

endmodule

// File: tb/tb_key_event_arb.sv
// Directed bench for key_event_arb: event ordering, latency, overflow, reset.
module tb_key_event_arb;
    import key_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] keycode;
    logic        ev_ready;
    logic        clr_ovf;
    logic        ev_valid;
    logic [7:0]  ev_code;
    logic        ev_press;
    logic        overflow;
    logic        any_key;

    int n_checks = 0;
    int n_fail   = 0;

    key_event_arb #(.FIFO_DEPTH(4)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .keycode  (keycode),
        .ev_ready (ev_ready),
        .clr_ovf  (clr_ovf),
        .ev_valid (ev_valid),
        .ev_code  (ev_code),
        .ev_press (ev_press),
        .overflow (overflow),
        .any_key  (any_key)
    );

    always #5 Clk = ~Clk;

    logic [9:0] obs;
    assign obs = {ev_valid, ev_code, ev_press};

    function automatic logic [9:0] ev(input logic [7:0] c, input logic p);
        return {1'b1, c, p};
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset    = 1'b1;
        keycode  = 16'h0000;
        ev_ready = 1'b0;
        clr_ovf  = 1'b0;
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({obs, overflow, any_key} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs got %h want 000", {obs, overflow, any_key});
        end
    endtask

    task automatic test_single_press();
        do_reset();
        ev_ready = 1'b1;
        keycode  = {KEY_NONE, KEY_ENTER};
        step();
        n_checks++;
        if ({obs, any_key} !== {10'h000, 1'b1}) begin
            n_fail++;
            $display("FAIL single_latency got %h want %h", {obs, any_key}, {10'h000, 1'b1});
        end
        step();
        n_checks++;
        if (obs !== ev(KEY_ENTER, 1'b1)) begin
            n_fail++;
            $display("FAIL single_event got %h want %h", obs, ev(KEY_ENTER, 1'b1));
        end
        step();
        n_checks++;
        if (obs !== 10'h000) begin
            n_fail++;
            $display("FAIL single_drained got %h want 000", obs);
        end
    endtask

    task automatic test_order();
        logic [9:0] exp [3];
        exp[0] = ev(KEY_ENTER, 1'b0);
        exp[1] = ev(KEY_A, 1'b1);
        exp[2] = ev(KEY_W, 1'b1);
        ev_ready = 1'b0;
        keycode  = {KEY_W, KEY_A};
        repeat (6) step();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL order_ev%0d got %h want %h", i, obs, exp[i]);
            end
            ev_ready = 1'b1;
            step();
            ev_ready = 1'b0;
        end
        n_checks++;
        if ({obs, overflow} !== 11'h000) begin
            n_fail++;
            $display("FAIL order_tail got %h want 000", {obs, overflow});
        end
    endtask

    task automatic test_overflow();
        logic [9:0] exp [4];
        exp[0] = ev(KEY_D, 1'b1);
        exp[1] = ev(KEY_A, 1'b1);
        exp[2] = ev(KEY_D, 1'b0);
        exp[3] = ev(KEY_A, 1'b0);
        do_reset();
        keycode = {KEY_A, KEY_D};
        repeat (4) step();
        keycode = 16'h0000;
        repeat (4) step();
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_full_no_drop got %b want 0", overflow);
        end
        keycode = {KEY_A, KEY_D};
        step();
        step();
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set got %b want 1", overflow);
        end
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set_beats_clr got %b want 1", overflow);
        end
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL ovf_ev%0d got %h want %h", i, obs, exp[i]);
            end
            ev_ready = 1'b1;
            step();
            ev_ready = 1'b0;
        end
        n_checks++;
        if ({obs, overflow} !== {10'h000, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_sticky got %h want %h", {obs, overflow}, {10'h000, 1'b1});
        end
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear got %b want 0", overflow);
        end
    endtask

    task automatic test_dup_swap();
        do_reset();
        ev_ready = 1'b1;
        keycode  = {KEY_ENTER, KEY_ENTER};
        step();
        step();
        n_checks++;
        if (obs !== ev(KEY_ENTER, 1'b1)) begin
            n_fail++;
            $display("FAIL dup_press got %h want %h", obs, ev(KEY_ENTER, 1'b1));
        end
        repeat (4) step();
        n_checks++;
        if (obs !== 10'h000) begin
            n_fail++;
            $display("FAIL dup_single got %h want 000", obs);
        end
        keycode = {KEY_A, KEY_ENTER};
        step();
        step();
        n_checks++;
        if (obs !== ev(KEY_A, 1'b1)) begin
            n_fail++;
            $display("FAIL dup_add_a got %h want %h", obs, ev(KEY_A, 1'b1));
        end
        step();
        keycode = {KEY_ENTER, KEY_A};
        repeat (4) step();
        n_checks++;
        if ({obs, any_key} !== {10'h000, 1'b1}) begin
            n_fail++;
            $display("FAIL swap_no_event got %h want %h", {obs, any_key}, {10'h000, 1'b1});
        end
        ev_ready = 1'b0;
        keycode  = 16'h0000;
        repeat (4) step();
        n_checks++;
        if (obs !== ev(KEY_A, 1'b0)) begin
            n_fail++;
            $display("FAIL swap_rel0 got %h want %h", obs, ev(KEY_A, 1'b0));
        end
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
        n_checks++;
        if ({obs, any_key} !== {ev(KEY_ENTER, 1'b0), 1'b0}) begin
            n_fail++;
            $display("FAIL swap_rel1 got %h want %h", {obs, any_key}, {ev(KEY_ENTER, 1'b0), 1'b0});
        end
    endtask

    task automatic test_net_change();
        logic [9:0] exp [4];
        exp[0] = ev(KEY_A, 1'b1);
        exp[1] = ev(KEY_A, 1'b0);
        exp[2] = ev(KEY_S, 1'b1);
        exp[3] = 10'h000;
        do_reset();
        keycode = {KEY_NONE, KEY_A};
        step();
        keycode = {KEY_NONE, KEY_S};
        repeat (6) step();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL net_ev%0d got %h want %h", i, obs, exp[i]);
            end
            ev_ready = 1'b1;
            step();
            ev_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid_emit();
        do_reset();
        keycode = {KEY_NONE, KEY_D};
        step();
        Reset = 1'b1;
        step();
        n_checks++;
        if ({obs, overflow, any_key} !== 12'h000) begin
            n_fail++;
            $display("FAIL rst_emit_clear got %h want 000", {obs, overflow, any_key});
        end
        Reset = 1'b0;
        step();
        step();
        n_checks++;
        if (obs !== ev(KEY_D, 1'b1)) begin
            n_fail++;
            $display("FAIL rst_emit_repress got %h want %h", obs, ev(KEY_D, 1'b1));
        end
        ev_ready = 1'b1;
        repeat (4) step();
        n_checks++;
        if (obs !== 10'h000) begin
            n_fail++;
            $display("FAIL rst_emit_single got %h want 000", obs);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp [7];
        exp[0] = ev(KEY_D, 1'b1);
        exp[1] = ev(KEY_A, 1'b1);
        exp[2] = ev(KEY_D, 1'b0);
        exp[3] = ev(KEY_A, 1'b0);
        exp[4] = ev(KEY_S, 1'b1);
        exp[5] = ev(KEY_ESC, 1'b1);
        exp[6] = 10'h000;
        do_reset();
        ev_ready = 1'b1;
        keycode  = {KEY_A, KEY_D};
        step();
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL b2b_ev%0d got %h want %h", i, obs, exp[i]);
            end
        end
        keycode = {KEY_ESC, KEY_S};
        step();
        for (int i = 2; i < 7; i++) begin
            step();
            n_checks++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL b2b_ev%0d got %h want %h", i, obs, exp[i]);
            end
        end
    endtask

    initial begin
        Reset    = 1'b1;
        keycode  = 16'h0000;
        ev_ready = 1'b0;
        clr_ovf  = 1'b0;
        test_reset();
        test_single_press();
        test_order();
        test_overflow();
        test_dup_swap();
        test_net_change();
        test_reset_mid_emit();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_event_arb.md
# key_event_arb

Converts the raw two-slot USB keyboard keycode into an ordered stream of discrete press/release events. Downstream consumers (game-state FSM, player controller, pause logic) pop them over a valid/ready handshake instead of polling level-sensitive keycodes. Sits between the keycode PIO register and every keycode consumer; removes missed or double-counted keypresses across state transitions.

## Interface
- FIFO_DEPTH, 4, event FIFO entries; power of two, ≥2
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high; clears all state
- keycode  in  16  two key slots, [15:8] slot1, [7:0] slot0; 8'h00 = empty slot
- ev_ready  in  1  consumer accepts head event this cycle
- clr_ovf  in  1  clears overflow flag
- ev_valid  out  1  FIFO non-empty; reset 0
- ev_code  out  8  head event keycode; reset 8'h00
- ev_press  out  1  1 = press, 0 = release; reset 0
- overflow  out  1  sticky, event dropped on full FIFO; reset 0
- any_key  out  1  registered, snapshot holds any nonzero slot; reset 0

## Operation
- snap_q[15:0]: last committed keycode, reset 16'h0000.
- FSM states: IDLE, EMIT. Reset → IDLE.
- IDLE: if keycode == snap_q, stay. Otherwise build four pending entries in fixed priority order:
  - (0) release snap_q[7:0]
  - (1) release snap_q[15:8]
  - (2) press keycode[7:0]
  - (3) press keycode[15:8]
- Release entry valid iff old code ≠ 0 and absent from both new slots. Press entry valid iff new code ≠ 0 and absent from both old slots.
- Duplicate suppression: if both slots of one snapshot hold the same nonzero code, only the slot0 entry is valid.
- On the same edge: snap_q ← keycode, any_key ← |keycode. If ≥1 entry is valid → EMIT, else stay IDLE (e.g. slot swap 28/04 → 04/28).
- EMIT: each cycle, take the lowest-index valid entry, push {code, press} to the FIFO, and clear that entry. Go to IDLE on the edge that clears the last entry. EMIT lasts exactly N cycles for N events.
- keycode is not sampled during EMIT. Changes are compared against snap_q on return to IDLE; intermediate states are lost, the net change is not.
- FIFO: show-ahead; ev_code/ev_press reflect the head entry. Pop when ev_valid && ev_ready.
- Push while full (count == FIFO_DEPTH at start of cycle): the event is dropped and overflow ← 1. This applies even if a pop happens the same cycle.
- Push and pop in the same cycle when not full: count unchanged, ordering preserved.
- overflow stays set until clr_ovf or Reset. If a drop and clr_ovf occur in the same cycle, the set wins.
- ev_code/ev_press are 8'h00/0 when empty.

## Timing
- Keycode change sampled at edge t (IDLE) → first push at edge t+1 → ev_valid high after edge t+1. Latency is 2 cycles.
- Back-to-back events: one per cycle into the FIFO. Consumer may pop one per cycle.
- Worst-case burst: 4 events (2 releases + 2 presses) in 4 consecutive cycles.
- Reset mid-EMIT: pending entries, FIFO, snap_q, and flags all cleared next edge. Keys still held afterwards generate fresh press events.

## Structure
- Shared package key_pkg:
  - typedef key_event_t {logic [7:0] code; logic press;}
  - FSM enum
  - Constants KEY_NONE 8'h00, KEY_ENTER 8'h28, KEY_ESC 8'h29, KEY_W 8'h1A, KEY_A 8'h04, KEY_S 8'h16, KEY_D 8'h07
- Sub-module event_fifo: synchronous FIFO of key_event_t, parameter FIFO_DEPTH.
  - Ports: push, push_data, pop, head, empty, full.
  - Full/empty from a count register, log2(FIFO_DEPTH)+1 bits.

## Test plan
- Reset, keycode 16'h0028, ev_ready=1 → exactly one event {28, press}, ev_valid high 2 cycles after change, any_key=1.
- Hold 16'h0028 and change to 16'h1A04 with ev_ready=0 → FIFO order {28, rel}, {04, press}, {1A, press}; overflow=0.
- FIFO_DEPTH=4, ev_ready=0, sequence 0000→0407→0000→0407 with each step held until IDLE → 6 events, first 4 retained, overflow=1; clr_ovf clears it.
- keycode 16'h2828 → single {28, press}. Then 28/04 swapped to 04/28 → no events, snap updated.
- Change keycode 0000→0004→0016 within the 1-cycle EMIT → events {04, press}, then {04, rel}, {16, press}. Net state is correct.
- Reset asserted mid-EMIT with keycode 16'h0007 held → outputs return to reset values. After release, exactly one {07, press}.
